// File: rtl/hex_edit_ctrl.sv
`timescale 1ns/1ps
// hex_edit_ctrl
// Button-driven editor for a bank of active-low seven-segment hex digits.
// In VIEW the committed value is displayed and may be overwritten through the
// load port. An edit press copies the value into a working register. In EDIT,
// next moves the cursor, inc bumps the selected nibble (no carry), and edit
// commits the working copy back to value. The selected digit blinks, and an
// idle timeout abandons the edit without committing.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   btn_edit/next/inc     raw active-high button levels
//   load_valid/load_data  request to overwrite value (accepted only in VIEW)
//   load_ready            high while a load would be accepted (VIEW)
//   value                 committed value, nibble i = digit i
//   commit                one-cycle pulse coincident with a newly committed value
//   editing               high in EDIT
//   cursor                selected digit index, 0 = least significant
//   seg                   digit i at [7i+6:7i], bit6=g..bit0=a, 0 = lit
module hex_edit_ctrl #(
   parameter int DIGITS    = 4,
   parameter int BLINK_DIV = 25000000,
   parameter int TIMEOUT   = 250000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                btn_edit,
   input  logic                btn_next,
   input  logic                btn_inc,
   input  logic                load_valid,
   input  logic [4*DIGITS-1:0] load_data,
   output logic                load_ready,
   output logic [4*DIGITS-1:0] value,
   output logic                commit,
   output logic                editing,
   output logic [2:0]          cursor,
   output logic [7*DIGITS-1:0] seg
);

   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam int IW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {VIEW, EDIT} state_t;

   state_t              state_q, state_d;
   logic [4*DIGITS-1:0] value_q, value_d;
   logic [4*DIGITS-1:0] work_q, work_d;
   logic [2:0]          cursor_q, cursor_d;
   logic                on_q, on_d;
   logic [BW-1:0]       blink_q, blink_d;
   logic [IW-1:0]       idle_q, idle_d;
   logic                commit_q, commit_d;
   logic                editing_q, editing_d;
   logic                load_ready_q, load_ready_d;
   logic [2:0]          btn_s_q, btn_s_d;
   logic [2:0]          btn_h_q, btn_h_d;
   logic                edit_pulse, next_pulse, inc_pulse;
   logic [4*DIGITS-1:0] shown;

   // Active-low glyph table for one hex nibble.
   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0: hex_glyph = 7'b1000000;
         4'h1: hex_glyph = 7'b1111001;
         4'h2: hex_glyph = 7'b0100100;
         4'h3: hex_glyph = 7'b0110000;
         4'h4: hex_glyph = 7'b0011001;
         4'h5: hex_glyph = 7'b0010010;
         4'h6: hex_glyph = 7'b0000010;
         4'h7: hex_glyph = 7'b1111000;
         4'h8: hex_glyph = 7'b0000000;
         4'h9: hex_glyph = 7'b0010000;
         4'hA: hex_glyph = 7'b0001000;
         4'hB: hex_glyph = 7'b0000011;
         4'hC: hex_glyph = 7'b1000110;
         4'hD: hex_glyph = 7'b0100001;
         4'hE: hex_glyph = 7'b0000110;
         default: hex_glyph = 7'b0001110;
      endcase
   endfunction

   // Buttons are sampled once, then compared against their previous sample so a
   // held button produces only a single pulse. Bit order is {inc, next, edit}.
   always_comb begin
      btn_s_d = {btn_inc, btn_next, btn_edit};
      btn_h_d = btn_s_q;
   end

   assign edit_pulse = btn_s_q[0] & ~btn_h_q[0];
   assign next_pulse = btn_s_q[1] & ~btn_h_q[1];
   assign inc_pulse  = btn_s_q[2] & ~btn_h_q[2];

   // Next-state logic. In EDIT an edit press wins over everything; otherwise any
   // press restarts the idle and blink timing so the cursor digit is lit while
   // the user is active. Counters sit at zero in VIEW.
   always_comb begin
      state_d  = state_q;
      value_d  = value_q;
      work_d   = work_q;
      cursor_d = cursor_q;
      on_d     = on_q;
      blink_d  = blink_q;
      idle_d   = idle_q;
      commit_d = 1'b0;
      case (state_q)
         VIEW: begin
            on_d    = 1'b1;
            blink_d = '0;
            idle_d  = '0;
            if (load_valid) begin
               value_d = load_data;
            end
            if (edit_pulse) begin
               state_d  = EDIT;
               work_d   = load_valid ? load_data : value_q;
               cursor_d = 3'd0;
            end
         end
         EDIT: begin
            if (edit_pulse) begin
               state_d  = VIEW;
               value_d  = work_q;
               commit_d = 1'b1;
               on_d     = 1'b1;
               blink_d  = '0;
               idle_d   = '0;
            end else if (inc_pulse || next_pulse) begin
               if (inc_pulse) begin
                  for (int i = 0; i < DIGITS; i++) begin
                     if (cursor_q == 3'(i)) begin
                        work_d[4*i +: 4] = work_q[4*i +: 4] + 4'd1;
                     end
                  end
               end
               if (next_pulse) begin
                  cursor_d = (cursor_q == 3'(DIGITS - 1)) ? 3'd0 : cursor_q + 3'd1;
               end
               on_d    = 1'b1;
               blink_d = '0;
               idle_d  = '0;
            end else if (idle_q == IW'(TIMEOUT - 1)) begin
               state_d = VIEW;
               on_d    = 1'b1;
               blink_d = '0;
               idle_d  = '0;
            end else begin
               idle_d = idle_q + IW'(1);
               if (blink_q == BW'(BLINK_DIV - 1)) begin
                  blink_d = '0;
                  on_d    = ~on_q;
               end else begin
                  blink_d = blink_q + BW'(1);
               end
            end
         end
         default: begin
            state_d = VIEW;
         end
      endcase
      editing_d    = (state_d == EDIT);
      load_ready_d = (state_d == VIEW);
   end

   // State register. editing and load_ready are kept as their own flops so the
   // outputs come straight from registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= VIEW;
         value_q      <= '0;
         work_q       <= '0;
         cursor_q     <= 3'd0;
         on_q         <= 1'b1;
         blink_q      <= '0;
         idle_q       <= '0;
         commit_q     <= 1'b0;
         editing_q    <= 1'b0;
         load_ready_q <= 1'b1;
         btn_s_q      <= 3'b000;
         btn_h_q      <= 3'b000;
      end else begin
         state_q      <= state_d;
         value_q      <= value_d;
         work_q       <= work_d;
         cursor_q     <= cursor_d;
         on_q         <= on_d;
         blink_q      <= blink_d;
         idle_q       <= idle_d;
         commit_q     <= commit_d;
         editing_q    <= editing_d;
         load_ready_q <= load_ready_d;
         btn_s_q      <= btn_s_d;
         btn_h_q      <= btn_h_d;
      end
   end

   assign shown = (state_q == EDIT) ? work_q : value_q;

   // Segment decode. The cursor digit is blanked during the off phase of the
   // blink, only while editing.
   always_comb begin
      seg = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if ((state_q == EDIT) && !on_q && (cursor_q == 3'(i))) begin
            seg[7*i +: 7] = 7'b1111111;
         end else begin
            seg[7*i +: 7] = hex_glyph(shown[4*i +: 4]);
         end
      end
   end

   assign value      = value_q;
   assign commit     = commit_q;
   assign editing    = editing_q;
   assign cursor     = cursor_q;
   assign load_ready = load_ready_q;

endmodule

// File: tb/tb_hex_edit_ctrl.sv
`timescale 1ns/1ps
// Testbench for hex_edit_ctrl with DIGITS=4, BLINK_DIV=4, TIMEOUT=20.
// Expected results are queued as stimulus is applied and compared after the
// clock edge that should produce them.
module tb_hex_edit_ctrl;

   localparam int DIGITS    = 4;
   localparam int BLINK_DIV = 4;
   localparam int TIMEOUT   = 20;

   localparam int SEL_VALUE   = 0;
   localparam int SEL_SEG     = 1;
   localparam int SEL_EDITING = 2;
   localparam int SEL_CURSOR  = 3;
   localparam int SEL_READY   = 4;
   localparam int SEL_COMMIT  = 5;
   localparam int SEL_DIGIT0  = 6;

   logic        clk;
   logic        rstN;
   logic        btnEdit, btnNext, btnInc;
   logic        loadValid;
   logic [15:0] loadData;
   logic        loadReady;
   logic [15:0] value;
   logic        commit;
   logic        editing;
   logic [2:0]  cursor;
   logic [27:0] seg;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } expect_t;

   expect_t     scoreboard[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          commitCount = 0;
   logic [15:0] lastCommitValue = '0;
   int          commitsBefore;

   hex_edit_ctrl #(
      .DIGITS(DIGITS),
      .BLINK_DIV(BLINK_DIV),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst_n(rstN),
      .btn_edit(btnEdit),
      .btn_next(btnNext),
      .btn_inc(btnInc),
      .load_valid(loadValid),
      .load_data(loadData),
      .load_ready(loadReady),
      .value(value),
      .commit(commit),
      .editing(editing),
      .cursor(cursor),
      .seg(seg)
   );

   // Free-running clock, rising edges at 5, 15, 25 ns ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts commit cycles and records the value seen alongside each one.
   always @(negedge clk) begin
      if (rstN && commit) begin
         commitCount++;
         lastCommitValue = value;
      end
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] table16 [16];
      table16 = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      return table16[n];
   endfunction

   function automatic logic [27:0] segOf(input logic [15:0] v);
      logic [27:0] r;
      for (int i = 0; i < DIGITS; i++) begin
         r[7*i +: 7] = glyph(v[4*i +: 4]);
      end
      return r;
   endfunction

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         SEL_VALUE:   return {16'h0, value};
         SEL_SEG:     return {4'h0, seg};
         SEL_EDITING: return {31'h0, editing};
         SEL_CURSOR:  return {29'h0, cursor};
         SEL_READY:   return {31'h0, loadReady};
         SEL_COMMIT:  return {31'h0, commit};
         default:     return {25'h0, seg[6:0]};
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic pushExpect(input string tag, input int sel, input logic [31:0] exp);
      expect_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      scoreboard.push_back(e);
   endtask

   task automatic drain();
      expect_t e;
      while (scoreboard.size() > 0) begin
         e = scoreboard.pop_front();
         checkOutput(e.tag, observe(e.sel), e.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic e, input logic n, input logic i);
      btnEdit = e;
      btnNext = n;
      btnInc  = i;
   endtask

   // Raise the given buttons and run to the edge where their effect lands.
   task automatic pressStart(input logic e, input logic n, input logic i);
      applyStimulus(e, n, i);
      tick();
      tick();
   endtask

   // Release all buttons and let the sampler see the low level.
   task automatic pressEnd();
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic loadValue(input logic [15:0] v);
      loadValid = 1'b1;
      loadData  = v;
      tick();
      loadValid = 1'b0;
   endtask

   initial begin
      rstN      = 1'b0;
      loadValid = 1'b0;
      loadData  = '0;
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Reset state
      #12;
      pushExpect("rst_seg", SEL_SEG, {4'h0, segOf(16'h0000)});
      pushExpect("rst_value", SEL_VALUE, 32'h0);
      pushExpect("rst_ready", SEL_READY, 32'h1);
      pushExpect("rst_editing", SEL_EDITING, 32'h0);
      pushExpect("rst_commit", SEL_COMMIT, 32'h0);
      drain();
      #10 rstN = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      pushExpect("idle_seg", SEL_SEG, {4'h0, segOf(16'h0000)});
      pushExpect("idle_ready", SEL_READY, 32'h1);
      drain();
      checkOutput("idle_commits", commitCount, 0);

      // Load in VIEW
      loadValue(16'h12AF);
      pushExpect("load_value", SEL_VALUE, 32'h12AF);
      pushExpect("load_seg", SEL_SEG, {4'h0, 7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110});
      drain();

      // Edit from zero: inc x3, next, inc, commit
      loadValue(16'h0000);
      pressStart(1'b1, 1'b0, 1'b0);
      pushExpect("enter_editing", SEL_EDITING, 32'h1);
      pushExpect("enter_cursor", SEL_CURSOR, 32'h0);
      pushExpect("enter_ready", SEL_READY, 32'h0);
      drain();
      pressEnd();
      for (int k = 0; k < 3; k++) begin
         pressStart(1'b0, 1'b0, 1'b1);
         pressEnd();
      end
      pressStart(1'b0, 1'b1, 1'b0);
      pushExpect("next_cursor", SEL_CURSOR, 32'h1);
      drain();
      pressEnd();
      pressStart(1'b0, 1'b0, 1'b1);
      pushExpect("edit_seg", SEL_SEG, {4'h0, segOf(16'h0013)});
      drain();
      pressEnd();
      commitsBefore = commitCount;
      pressStart(1'b1, 1'b0, 1'b0);
      pushExpect("commit_pulse", SEL_COMMIT, 32'h1);
      pushExpect("commit_value", SEL_VALUE, 32'h0013);
      pushExpect("commit_editing", SEL_EDITING, 32'h0);
      pushExpect("commit_cursor", SEL_CURSOR, 32'h1);
      drain();
      pressEnd();
      pushExpect("commit_low", SEL_COMMIT, 32'h0);
      drain();
      checkOutput("commit_count", commitCount - commitsBefore, 1);
      checkOutput("commit_seen_value", {16'h0, lastCommitValue}, 32'h0013);

      // Nibble wrap without carry, cursor wrap, inc+next together
      loadValue(16'hF00F);
      pressStart(1'b1, 1'b0, 1'b0);
      pressEnd();
      pressStart(1'b0, 1'b0, 1'b1);
      pushExpect("wrap_nib0_seg", SEL_SEG, {4'h0, segOf(16'hF000)});
      drain();
      pressEnd();
      for (int k = 0; k < 3; k++) begin
         pressStart(1'b0, 1'b1, 1'b0);
         pressEnd();
      end
      pushExpect("cursor_at_3", SEL_CURSOR, 32'h3);
      drain();
      pressStart(1'b0, 1'b0, 1'b1);
      pushExpect("wrap_nib3_seg", SEL_SEG, {4'h0, segOf(16'h0000)});
      drain();
      pressEnd();
      pressStart(1'b0, 1'b1, 1'b0);
      pushExpect("cursor_wrap", SEL_CURSOR, 32'h0);
      drain();
      pressEnd();
      pressStart(1'b0, 1'b1, 1'b1);
      pushExpect("incnext_cursor", SEL_CURSOR, 32'h1);
      pushExpect("incnext_seg", SEL_SEG, {4'h0, segOf(16'h0001)});
      drain();
      pressEnd();
      pressStart(1'b1, 1'b0, 1'b0);
      pushExpect("wrap_commit_value", SEL_VALUE, 32'h0001);
      drain();
      pressEnd();

      // Blink and timeout with an ignored load
      commitsBefore = commitCount;
      pressStart(1'b1, 1'b0, 1'b0);
      pushExpect("to_enter", SEL_EDITING, 32'h1);
      drain();
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= TIMEOUT; k++) begin
         if (k == 5) begin
            loadValid = 1'b1;
            loadData  = 16'hBEEF;
         end
         if (k == 12) loadValid = 1'b0;
         tick();
         if (k < TIMEOUT) begin
            pushExpect($sformatf("blink_k%0d", k), SEL_DIGIT0,
                       ((k / BLINK_DIV) % 2 == 0) ? 32'h79 : 32'h7F);
         end
         if (k == 10) pushExpect("edit_ready_low", SEL_READY, 32'h0);
         if (k == TIMEOUT - 1) pushExpect("to_still_edit", SEL_EDITING, 32'h1);
         drain();
      end
      pushExpect("to_exit", SEL_EDITING, 32'h0);
      pushExpect("to_value", SEL_VALUE, 32'h0001);
      pushExpect("to_ready", SEL_READY, 32'h1);
      pushExpect("to_seg", SEL_SEG, {4'h0, segOf(16'h0001)});
      drain();
      checkOutput("to_no_commit", commitCount - commitsBefore, 0);

      // Reset mid-EDIT with inc held
      pressStart(1'b1, 1'b0, 1'b0);
      pressEnd();
      pressStart(1'b0, 1'b1, 1'b0);
      pressEnd();
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick();
      #2 rstN = 1'b0;
      #1;
      pushExpect("rst2_editing", SEL_EDITING, 32'h0);
      pushExpect("rst2_value", SEL_VALUE, 32'h0);
      pushExpect("rst2_cursor", SEL_CURSOR, 32'h0);
      pushExpect("rst2_seg", SEL_SEG, {4'h0, segOf(16'h0000)});
      pushExpect("rst2_ready", SEL_READY, 32'h1);
      drain();
      tick();
      tick();
      #4 rstN = 1'b1;
      tick();
      tick();
      pushExpect("rst2_view", SEL_EDITING, 32'h0);
      pushExpect("rst2_value_kept", SEL_VALUE, 32'h0);
      drain();
      commitsBefore = commitCount;
      pressStart(1'b1, 1'b0, 1'b1);
      pushExpect("held_inc_enter", SEL_EDITING, 32'h1);
      drain();
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick();
      pushExpect("held_inc_norepeat", SEL_SEG, {4'h0, segOf(16'h0000)});
      drain();
      pressStart(1'b1, 1'b0, 1'b1);
      pushExpect("held_inc_commit", SEL_VALUE, 32'h0000);
      pushExpect("held_inc_pulse", SEL_COMMIT, 32'h1);
      drain();
      pressEnd();
      checkOutput("held_inc_commits", commitCount - commitsBefore, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
